led_bz_driver: RTL and testbench

LED_BZ_DRIVER -- requirements
Module: led_bz_driver

---
 rtl/led_bz_driver.sv | 188 ++++++++++++++++++
 tb/tb_led_bz_driver.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_bz_driver.sv
// LED PWM and buzzer driver.
// Synchronizes the {bz_req, r, g, b} pattern from the divided-clock domain,
// gates the three LED channels with an 8-bit PWM, and plays one fixed-length
// tone per rising edge of bz_req, followed by a lockout that discards requests.
module led_bz_driver #(
    parameter int unsigned TONE_HALF = 12500,
    parameter int unsigned BEEP_LEN  = 5000000,
    parameter int unsigned LOCK_LEN  = 2500000
) (
    input  logic       i_sysclk,
    input  logic       RST_n,
    input  logic [3:0] i_data,
    input  logic [7:0] i_duty,
    output logic       BZ,
    output logic       LED_R,
    output logic       LED_G,
    output logic       LED_B,
    output logic       o_busy
);

    localparam int unsigned MAX_LEN = (BEEP_LEN > LOCK_LEN) ? BEEP_LEN : LOCK_LEN;
    localparam int unsigned TMR_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned TONE_W  = (TONE_HALF > 1) ? $clog2(TONE_HALF) : 1;

    localparam logic [TMR_W-1:0]  BEEP_LOAD = TMR_W'(BEEP_LEN - 1);
    localparam logic [TMR_W-1:0]  LOCK_LOAD = TMR_W'(LOCK_LEN - 1);
    localparam logic [TONE_W-1:0] TONE_LAST = TONE_W'(TONE_HALF - 1);

    typedef enum logic [1:0] {
        StIdle,
        StBeep,
        StLockout
    } state_e;

    logic [3:0]        r_sync1;
    logic [3:0]        r_sync2;
    logic              r_bz_prev;
    logic [7:0]        r_pwm_cnt;
    logic [7:0]        r_duty_q;
    logic [2:0]        r_led;

    state_e            r_state;
    logic [TMR_W-1:0]  r_timer;
    logic [TONE_W-1:0] r_tone_cnt;
    logic              r_tone;
    logic              r_bz;
    logic              r_busy;

    state_e            w_state_d;
    logic [TMR_W-1:0]  w_timer_d;
    logic [TONE_W-1:0] w_tone_cnt_d;
    logic              w_tone_d;
    logic              w_bz_d;
    logic              w_busy_d;
    logic              w_rise;
    logic              w_gate;
    logic [2:0]        w_led_on;

    // Two-flop synchronizer plus the previous-value flop for bz_req edge detect.
    always_ff @(posedge i_sysclk or negedge RST_n) begin
        if (!RST_n) begin
            r_sync1   <= 4'b0000;
            r_sync2   <= 4'b0000;
            r_bz_prev <= 1'b0;
        end else begin
            r_sync1   <= i_data;
            r_sync2   <= r_sync1;
            r_bz_prev <= r_sync2[3];
        end
    end

    assign w_rise = r_sync2[3] & ~r_bz_prev;

    // Free-running PWM counter; duty is sampled once per period so mid-period
    // changes never produce a glitched period.
    always_ff @(posedge i_sysclk or negedge RST_n) begin
        if (!RST_n) begin
            r_pwm_cnt <= 8'd0;
            r_duty_q  <= 8'd0;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 8'd1;
            if (r_pwm_cnt == 8'hFF) begin
                r_duty_q <= i_duty;
            end
        end
    end

    // PWM gate: 255 is fully on, otherwise on for pwm_cnt in [0, duty).
    always_comb begin
        w_gate   = (r_duty_q == 8'hFF) || (r_pwm_cnt < r_duty_q);
        w_led_on = r_sync2[2:0] & {3{w_gate}};
    end

    // Registered active-low LED drives; bit 2 is red, bit 1 green, bit 0 blue.
    always_ff @(posedge i_sysclk or negedge RST_n) begin
        if (!RST_n) begin
            r_led <= 3'b111;
        end else begin
            r_led <= ~w_led_on;
        end
    end

    // Buzzer FSM state, timer and tone generator registers.
    always_ff @(posedge i_sysclk or negedge RST_n) begin
        if (!RST_n) begin
            r_state    <= StIdle;
            r_timer    <= '0;
            r_tone_cnt <= '0;
            r_tone     <= 1'b0;
        end else begin
            r_state    <= w_state_d;
            r_timer    <= w_timer_d;
            r_tone_cnt <= w_tone_cnt_d;
            r_tone     <= w_tone_d;
        end
    end

    // Next-state logic; edges outside IDLE are dropped, never queued.
    always_comb begin
        w_state_d    = r_state;
        w_timer_d    = r_timer;
        w_tone_cnt_d = r_tone_cnt;
        w_tone_d     = r_tone;
        unique case (r_state)
            StIdle: begin
                if (w_rise) begin
                    w_state_d    = StBeep;
                    w_timer_d    = BEEP_LOAD;
                    w_tone_cnt_d = '0;
                    w_tone_d     = 1'b1;
                end
            end
            StBeep: begin
                if (r_timer == '0) begin
                    w_state_d    = StLockout;
                    w_timer_d    = LOCK_LOAD;
                    w_tone_cnt_d = '0;
                    w_tone_d     = 1'b0;
                end else begin
                    w_timer_d = r_timer - TMR_W'(1);
                    if (r_tone_cnt == TONE_LAST) begin
                        w_tone_cnt_d = '0;
                        w_tone_d     = ~r_tone;
                    end else begin
                        w_tone_cnt_d = r_tone_cnt + TONE_W'(1);
                    end
                end
            end
            StLockout: begin
                if (r_timer == '0) begin
                    w_state_d = StIdle;
                end else begin
                    w_timer_d = r_timer - TMR_W'(1);
                end
            end
            default: begin
                w_state_d    = StIdle;
                w_timer_d    = '0;
                w_tone_cnt_d = '0;
                w_tone_d     = 1'b0;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs track the state register.
    always_comb begin
        w_busy_d = (w_state_d != StIdle);
        w_bz_d   = ~(w_tone_d & (w_state_d == StBeep));
    end

    // Registered buzzer and busy outputs.
    always_ff @(posedge i_sysclk or negedge RST_n) begin
        if (!RST_n) begin
            r_bz   <= 1'b1;
            r_busy <= 1'b0;
        end else begin
            r_bz   <= w_bz_d;
            r_busy <= w_busy_d;
        end
    end

    assign BZ     = r_bz;
    assign LED_R  = r_led[2];
    assign LED_G  = r_led[1];
    assign LED_B  = r_led[0];
    assign o_busy = r_busy;

endmodule

// File: tb/tb_led_bz_driver.sv
// Directed testbench for led_bz_driver with short tone/beep/lockout lengths.
module tb_led_bz_driver;

    localparam int unsigned TONE_HALF = 4;
    localparam int unsigned BEEP_LEN  = 20;
    localparam int unsigned LOCK_LEN  = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] data;
    logic [7:0] duty;
    logic       bz;
    logic       led_r;
    logic       led_g;
    logic       led_b;
    logic       busy;

    int total = 0;
    int bad   = 0;
    int k_cyc = 0;   // posedges since last reset release == expected pwm_cnt

    always #5 clk = ~clk;

    led_bz_driver #(
        .TONE_HALF (TONE_HALF),
        .BEEP_LEN  (BEEP_LEN),
        .LOCK_LEN  (LOCK_LEN)
    ) dut (
        .i_sysclk (clk),
        .RST_n    (rst_n),
        .i_data   (data),
        .i_duty   (duty),
        .BZ       (bz),
        .LED_R    (led_r),
        .LED_G    (led_g),
        .LED_B    (led_b),
        .o_busy   (busy)
    );

    task automatic tick();
        @(posedge clk);
        k_cyc++;
        #1;
    endtask

    // Expected busy / BZ, d = ticks since the beep's first BEEP cycle.
    function automatic logic exp_busy(int d);
        return (d >= 0) && (d < 30);
    endfunction

    function automatic logic exp_bz(int d);
        if (d >= 0 && d < 20) return ((d / 4) % 2) != 0;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        data  = 4'b1111;
        duty  = 8'd255;
        tick();
        tick();
        total++;
        if (bz !== 1'b1) begin
            bad++; $display("FAIL reset_bz: got %b want 1", bz);
        end
        total++;
        if ({led_r, led_g, led_b} !== 3'b111) begin
            bad++; $display("FAIL reset_led: got %b want 111", {led_r, led_g, led_b});
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        data  = 4'b0000;
        rst_n = 1'b1;
        k_cyc = 0;
        tick();
        total++;
        if ({bz, led_r, led_g, led_b, busy} !== 5'b11110) begin
            bad++; $display("FAIL reset_release: got %b want 11110",
                            {bz, led_r, led_g, led_b, busy});
        end
    endtask

    task automatic test_full_duty();
        int errs = 0;
        repeat (260) tick();
        data = 4'b0111;
        tick();
        tick();
        total++;
        if ({led_r, led_g, led_b} !== 3'b111) begin
            bad++; $display("FAIL full_latency2: got %b want 111", {led_r, led_g, led_b});
        end
        tick();
        total++;
        if ({led_r, led_g, led_b} !== 3'b000) begin
            bad++; $display("FAIL full_latency3: got %b want 000", {led_r, led_g, led_b});
        end
        for (int i = 0; i < 300; i++) begin
            tick();
            if ({led_r, led_g, led_b} !== 3'b000 || bz !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL full_steady: got %0d bad cycles want 0", errs);
        end
    endtask

    task automatic test_pwm();
        int lows = 0;
        int phase_err = 0;
        int gb_err = 0;
        int off_err = 0;
        int p;
        logic e;
        duty = 8'd64;
        data = 4'b0100;
        repeat (3) tick();
        do tick(); while (k_cyc % 256 != 0);
        for (int i = 0; i < 256; i++) begin
            tick();
            p = (k_cyc - 1) % 256;
            e = (p < 64) ? 1'b0 : 1'b1;
            if (led_r !== e) phase_err++;
            if (led_r === 1'b0) lows++;
            if ({led_g, led_b} !== 2'b11) gb_err++;
        end
        total++;
        if (lows != 64) begin
            bad++; $display("FAIL pwm64_lows: got %0d want 64", lows);
        end
        total++;
        if (phase_err != 0) begin
            bad++; $display("FAIL pwm64_phase: got %0d bad cycles want 0", phase_err);
        end
        total++;
        if (gb_err != 0) begin
            bad++; $display("FAIL pwm64_gb_off: got %0d bad cycles want 0", gb_err);
        end
        duty = 8'd0;
        do tick(); while (k_cyc % 256 != 0);
        for (int i = 0; i < 256; i++) begin
            tick();
            if (led_r !== 1'b1) off_err++;
        end
        total++;
        if (off_err != 0) begin
            bad++; $display("FAIL pwm0_off: got %0d bad cycles want 0", off_err);
        end
    endtask

    task automatic test_beep();
        data = 4'b0000;
        repeat (4) tick();
        data = 4'b1000;
        for (int n = 1; n <= 36; n++) begin
            tick();
            if (n == 2) data = 4'b0000;
            total++;
            if (busy !== exp_busy(n - 3)) begin
                bad++; $display("FAIL beep_busy n=%0d: got %b want %b", n, busy, exp_busy(n - 3));
            end
            total++;
            if (bz !== exp_bz(n - 3)) begin
                bad++; $display("FAIL beep_bz n=%0d: got %b want %b", n, bz, exp_bz(n - 3));
            end
        end
    endtask

    task automatic test_discard();
        logic eb;
        logic ebz;
        data = 4'b0000;
        repeat (4) tick();
        data = 4'b1000;
        for (int n = 1; n <= 72; n++) begin
            tick();
            if (n == 2 || n == 10 || n == 28 || n == 36) data = 4'b0000;
            if (n == 8 || n == 26 || n == 34) data = 4'b1000;
            eb  = exp_busy(n - 3) | exp_busy(n - 37);
            ebz = exp_bz(n - 3) & exp_bz(n - 37);
            total++;
            if (busy !== eb) begin
                bad++; $display("FAIL discard_busy n=%0d: got %b want %b", n, busy, eb);
            end
            total++;
            if (bz !== ebz) begin
                bad++; $display("FAIL discard_bz n=%0d: got %b want %b", n, bz, ebz);
            end
        end
    endtask

    task automatic test_lockout_edge();
        data = 4'b0000;
        repeat (4) tick();
        data = 4'b1000;
        for (int n = 1; n <= 46; n++) begin
            tick();
            if (n == 2) data = 4'b0000;
            if (n == 30) data = 4'b1000;
            total++;
            if (busy !== exp_busy(n - 3)) begin
                bad++; $display("FAIL lockexit_busy n=%0d: got %b want %b",
                                n, busy, exp_busy(n - 3));
            end
            total++;
            if (bz !== exp_bz(n - 3)) begin
                bad++; $display("FAIL lockexit_bz n=%0d: got %b want %b", n, bz, exp_bz(n - 3));
            end
        end
        data = 4'b0000;
        repeat (4) tick();
    endtask

    task automatic test_reset_mid_beep();
        int errs = 0;
        duty = 8'd255;
        data = 4'b0111;
        do tick(); while (k_cyc % 256 != 0);
        repeat (3) tick();
        total++;
        if ({led_r, led_g, led_b} !== 3'b000) begin
            bad++; $display("FAIL midrst_led_pre: got %b want 000", {led_r, led_g, led_b});
        end
        data = 4'b1111;
        for (int n = 1; n <= 11; n++) begin
            tick();
            if (n == 2) data = 4'b0111;
        end
        total++;
        if ({busy, bz} !== 2'b10) begin
            bad++; $display("FAIL midrst_pre: got busy,bz=%b want 10", {busy, bz});
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (bz !== 1'b1) begin
            bad++; $display("FAIL midrst_bz: got %b want 1", bz);
        end
        total++;
        if (busy !== 1'b0) begin
            bad++; $display("FAIL midrst_busy: got %b want 0", busy);
        end
        total++;
        if ({led_r, led_g, led_b} !== 3'b111) begin
            bad++; $display("FAIL midrst_led: got %b want 111", {led_r, led_g, led_b});
        end
        tick();
        tick();
        rst_n = 1'b1;
        k_cyc = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (busy !== 1'b0 || bz !== 1'b1) errs++;
        end
        total++;
        if (errs != 0) begin
            bad++; $display("FAIL midrst_no_lockout: got %0d bad cycles want 0", errs);
        end
    endtask

    task automatic test_release_high();
        rst_n = 1'b0;
        data  = 4'b1000;
        tick();
        tick();
        rst_n = 1'b1;
        k_cyc = 0;
        for (int n = 1; n <= 50; n++) begin
            tick();
            total++;
            if (busy !== exp_busy(n - 3)) begin
                bad++; $display("FAIL relhigh_busy n=%0d: got %b want %b",
                                n, busy, exp_busy(n - 3));
            end
            total++;
            if (bz !== exp_bz(n - 3)) begin
                bad++; $display("FAIL relhigh_bz n=%0d: got %b want %b", n, bz, exp_bz(n - 3));
            end
        end
    endtask

    task automatic test_duty_change();
        int cur_err = 0;
        int nxt_err = 0;
        int nxt_lows = 0;
        int p;
        int dq;
        logic in_next = 1'b0;
        logic e;
        data = 4'b0100;
        duty = 8'd32;
        repeat (3) tick();
        do tick(); while (k_cyc % 256 != 0);
        while (k_cyc % 256 != 100) tick();
        duty = 8'd200;
        for (int i = 0; i < 412; i++) begin
            p  = k_cyc % 256;
            dq = in_next ? 200 : 32;
            tick();
            e = (p < dq) ? 1'b0 : 1'b1;
            if (led_r !== e) begin
                if (in_next) nxt_err++;
                else cur_err++;
            end
            if (in_next && led_r === 1'b0) nxt_lows++;
            if (p == 255) in_next = 1'b1;
        end
        total++;
        if (cur_err != 0) begin
            bad++; $display("FAIL duty_cur_period: got %0d bad cycles want 0", cur_err);
        end
        total++;
        if (nxt_err != 0) begin
            bad++; $display("FAIL duty_next_period: got %0d bad cycles want 0", nxt_err);
        end
        total++;
        if (nxt_lows != 200) begin
            bad++; $display("FAIL duty_next_lows: got %0d want 200", nxt_lows);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        data  = 4'b0000;
        duty  = 8'd0;
        test_reset();
        test_full_duty();
        test_pwm();
        test_beep();
        test_discard();
        test_lockout_edge();
        test_reset_mid_beep();
        test_release_high();
        test_duty_change();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
